// File: rtl/tri_span_gen_if.sv
// Triangle load port and span output stream of tri_span_gen.
// master = the span generator, slave = whoever feeds triangles and consumes spans.
interface tri_span_gen_if #(
  parameter int COORD_W = 11
);
  logic [COORD_W-1:0] td_xa, td_ya, td_xb, td_yb, td_xc, td_yc;
  logic [COORD_W-1:0] ts_xa, ts_ya, ts_xb, ts_yb, ts_xc, ts_yc;
  logic               t_load;
  logic               t_finished;
  logic               sp_valid;
  logic               sp_ready;
  logic [COORD_W-1:0] sp_y, sp_xl, sp_xr, sp_sxl, sp_syl, sp_sxr, sp_syr;

  modport master (
    input  td_xa, td_ya, td_xb, td_yb, td_xc, td_yc,
    input  ts_xa, ts_ya, ts_xb, ts_yb, ts_xc, ts_yc,
    input  t_load, sp_ready,
    output t_finished, sp_valid,
    output sp_y, sp_xl, sp_xr, sp_sxl, sp_syl, sp_sxr, sp_syr
  );

  modport slave (
    output td_xa, td_ya, td_xb, td_yb, td_xc, td_yc,
    output ts_xa, ts_ya, ts_xb, ts_yb, ts_xc, ts_yc,
    output t_load, sp_ready,
    input  t_finished, sp_valid,
    input  sp_y, sp_xl, sp_xr, sp_sxl, sp_syl, sp_sxr, sp_syr
  );
endinterface

// File: rtl/tri_span_gen.sv
// Triangle edge walker: sorts vertices by dst y, DDA-walks the long and short edges and
// emits one [xl,xr) span per scanline. Define TRI_SPAN_CLIP_EN to clip against HRES x VRES.
module tri_span_gen #(
  parameter int COORD_W = 11
`ifdef TRI_SPAN_CLIP_EN
  , parameter int HRES = 640
  , parameter int VRES = 480
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  tri_span_gen_if.master bus
);
  localparam int DW = COORD_W + 1;
  localparam int SP_Y = 0, SP_XL = 1, SP_XR = 2, SP_SXL = 3, SP_SYL = 4, SP_SXR = 5, SP_SYR = 6;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic signed [DW-1:0] delta_t;
  typedef logic [DW-1:0]        err_t;
  typedef enum logic [2:0] {IDLE, SORT, SETUP, WALK, EMIT, OUT, ADVANCE} state_t;

  // Vertex fields 0..2 (dst x, src x, src y) double as DDA channels; field 3 is dst y.
  coord_t     vert_q [3][4];
  coord_t     vert_d [3][4];
  coord_t     val_q  [2][3];
  coord_t     val_d  [2][3];
  coord_t     end_q  [2][3];
  coord_t     end_d  [2][3];
  delta_t     dq_q   [2][3];
  delta_t     dq_d   [2][3];
  err_t       err_q  [2][3];
  err_t       err_d  [2][3];
  coord_t     dy_q   [2];
  coord_t     dy_d   [2];
  coord_t     sp_q   [7];
  coord_t     sp_d   [7];
  coord_t     y_q, y_d;
  logic       s_idx_q, s_idx_d;
  logic [1:0] sort_cnt_q, sort_cnt_d;
  logic       sp_valid_q, sp_valid_d;
  state_t     state_q, state_d;

  logic       left_s;
  coord_t     xl, xr, xr_out, y_n;
  logic       top_clip, y_n_clip, x_clip;
  logic       do_adv, any_step;
  logic       ld     [2];
  logic [1:0] from_i [2];
  logic [1:0] to_i   [2];

  function automatic err_t mag(delta_t d);
    return d[DW-1] ? err_t'(-d) : err_t'(d);
  endfunction

  assign left_s = val_q[1][0] < val_q[0][0];
  assign xl     = left_s ? val_q[1][0] : val_q[0][0];
  assign xr     = left_s ? val_q[0][0] : val_q[1][0];
  assign y_n    = y_q + coord_t'(1);

`ifdef TRI_SPAN_CLIP_EN
  localparam coord_t HRES_C = coord_t'(HRES);
  localparam coord_t VRES_C = coord_t'(VRES);
  assign top_clip = vert_q[0][3] >= VRES_C;
  assign y_n_clip = y_n >= VRES_C;
  assign x_clip   = xl >= HRES_C;
  assign xr_out   = (xr > HRES_C) ? HRES_C : xr;
`else
  assign top_clip = 1'b0;
  assign y_n_clip = 1'b0;
  assign x_clip   = 1'b0;
  assign xr_out   = xr;
`endif

  always_comb begin
    state_d    = state_q;
    vert_d     = vert_q;
    val_d      = val_q;
    end_d      = end_q;
    dq_d       = dq_q;
    err_d      = err_q;
    dy_d       = dy_q;
    sp_d       = sp_q;
    y_d        = y_q;
    s_idx_d    = s_idx_q;
    sort_cnt_d = sort_cnt_q;
    sp_valid_d = sp_valid_q;
    do_adv     = 1'b0;
    any_step   = 1'b0;
    ld[0]      = 1'b0;
    ld[1]      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.t_load) begin
          vert_d[0]  = '{bus.td_xa, bus.ts_xa, bus.ts_ya, bus.td_ya};
          vert_d[1]  = '{bus.td_xb, bus.ts_xb, bus.ts_yb, bus.td_yb};
          vert_d[2]  = '{bus.td_xc, bus.ts_xc, bus.ts_yc, bus.td_yc};
          sort_cnt_d = '0;
          state_d    = SORT;
        end
      end
      SORT: begin
        // Pairs (0,1),(1,2),(0,1); strict compare keeps equal-y vertices in input order.
        if (sort_cnt_q == 2'd1) begin
          if (vert_q[1][3] > vert_q[2][3]) begin
            vert_d[1] = vert_q[2];
            vert_d[2] = vert_q[1];
          end
        end else if (vert_q[0][3] > vert_q[1][3]) begin
          vert_d[0] = vert_q[1];
          vert_d[1] = vert_q[0];
        end
        sort_cnt_d = sort_cnt_q + 2'd1;
        if (sort_cnt_q == 2'd2) state_d = SETUP;
      end
      SETUP: begin
        y_d = vert_q[0][3];
        if (vert_q[0][3] == vert_q[2][3] || top_clip) begin
          state_d = IDLE;
        end else begin
          ld[0]   = 1'b1;
          ld[1]   = 1'b1;
          s_idx_d = (vert_q[0][3] == vert_q[1][3]);
          state_d = EMIT;
        end
      end
      WALK: begin
        for (int e = 0; e < 2; e++) begin
          for (int c = 0; c < 3; c++) begin
            if (err_q[e][c] >= {1'b0, dy_q[e]} && val_q[e][c] != end_q[e][c]) begin
              any_step    = 1'b1;
              val_d[e][c] = dq_q[e][c][DW-1] ? val_q[e][c] - coord_t'(1) : val_q[e][c] + coord_t'(1);
              err_d[e][c] = err_q[e][c] - {1'b0, dy_q[e]};
            end
          end
        end
        if (!any_step) state_d = EMIT;
      end
      EMIT: begin
        if (xl == xr || x_clip) begin
          state_d = ADVANCE;
        end else begin
          sp_d[SP_Y]   = y_q;
          sp_d[SP_XL]  = xl;
          sp_d[SP_XR]  = xr_out;
          sp_d[SP_SXL] = left_s ? val_q[1][1] : val_q[0][1];
          sp_d[SP_SYL] = left_s ? val_q[1][2] : val_q[0][2];
          sp_d[SP_SXR] = left_s ? val_q[0][1] : val_q[1][1];
          sp_d[SP_SYR] = left_s ? val_q[0][2] : val_q[1][2];
          sp_valid_d   = 1'b1;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (bus.sp_ready) begin
          sp_valid_d = 1'b0;
          do_adv     = 1'b1;
        end
      end
      ADVANCE: do_adv = 1'b1;
      default: state_d = IDLE;
    endcase

    // Advancing also charges every channel with one row's worth of |dq|.
    if (do_adv) begin
      y_d = y_n;
      for (int e = 0; e < 2; e++) begin
        for (int c = 0; c < 3; c++) begin
          err_d[e][c] = err_q[e][c] + mag(dq_q[e][c]);
        end
      end
      if (y_n == vert_q[1][3] && !s_idx_q) begin
        ld[1]   = 1'b1;
        s_idx_d = 1'b1;
      end
      state_d = (y_n == vert_q[2][3] || y_n_clip) ? IDLE : WALK;
    end

    from_i[0] = 2'd0;
    to_i[0]   = 2'd2;
    from_i[1] = {1'b0, s_idx_d};
    to_i[1]   = s_idx_d ? 2'd2 : 2'd1;
    for (int e = 0; e < 2; e++) begin
      if (ld[e]) begin
        for (int c = 0; c < 3; c++) begin
          val_d[e][c] = vert_q[from_i[e]][c];
          end_d[e][c] = vert_q[to_i[e]][c];
          dq_d[e][c]  = $signed({1'b0, vert_q[to_i[e]][c]}) - $signed({1'b0, vert_q[from_i[e]][c]});
          err_d[e][c] = '0;
        end
        dy_d[e] = vert_q[to_i[e]][3] - vert_q[from_i[e]][3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vert_q     <= '{default: '0};
      val_q      <= '{default: '0};
      end_q      <= '{default: '0};
      dq_q       <= '{default: '0};
      err_q      <= '{default: '0};
      dy_q       <= '{default: '0};
      sp_q       <= '{default: '0};
      y_q        <= '0;
      s_idx_q    <= 1'b0;
      sort_cnt_q <= '0;
      sp_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vert_q     <= vert_d;
      val_q      <= val_d;
      end_q      <= end_d;
      dq_q       <= dq_d;
      err_q      <= err_d;
      dy_q       <= dy_d;
      sp_q       <= sp_d;
      y_q        <= y_d;
      s_idx_q    <= s_idx_d;
      sort_cnt_q <= sort_cnt_d;
      sp_valid_q <= sp_valid_d;
    end
  end

  assign bus.t_finished = (state_q == IDLE);
  assign bus.sp_valid   = sp_valid_q;
  assign bus.sp_y       = sp_q[SP_Y];
  assign bus.sp_xl      = sp_q[SP_XL];
  assign bus.sp_xr      = sp_q[SP_XR];
  assign bus.sp_sxl     = sp_q[SP_SXL];
  assign bus.sp_syl     = sp_q[SP_SYL];
  assign bus.sp_sxr     = sp_q[SP_SXR];
  assign bus.sp_syr     = sp_q[SP_SYR];
endmodule
